// File: rtl/pulse_checker.sv
// pulse_checker: receive-side monitor for the BIST pulse-generator burst train.
// Checks M_MAX+1 bursts of exactly N_MAX high samples, separated by single low
// samples, followed by QUIET_CYC low samples. Reports a sticky pass/fail verdict,
// an error code and the number of correctly-lengthed bursts seen.
module pulse_checker #(
    parameter int unsigned N_MAX     = 18,  // high length of each burst (2..31)
    parameter int unsigned M_MAX     = 512, // number of low gaps, bursts = M_MAX+1 (<= 1021)
    parameter int unsigned TIMEOUT   = 64,  // low samples tolerated before the first burst
    parameter int unsigned QUIET_CYC = 4    // low samples required after the last burst
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_arm,
    input  logic       i_pulse_in,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic       o_fail,
    output logic [2:0] o_err_code,
    output logic [9:0] o_bursts
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFirst,
        StHigh,
        StGap,
        StQuiet,
        StPass,
        StFail
    } state_t;

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrTimeout = 3'd1;
    localparam logic [2:0] ErrShort   = 3'd2;
    localparam logic [2:0] ErrLong    = 3'd3;
    localparam logic [2:0] ErrGap     = 3'd4;
    localparam logic [2:0] ErrExtra   = 3'd5;

    localparam logic [4:0] HcntMax    = 5'(N_MAX);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam logic [7:0] QuietCnt   = 8'(QUIET_CYC);
    localparam logic [9:0] BurstsLast = 10'(M_MAX + 1);

    state_t      r_state;
    logic        r_p;
    logic [4:0]  r_hcnt;
    logic [7:0]  r_lcnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic [2:0]  r_err;
    logic [9:0]  r_bursts;

    logic        w_hcnt_full;
    logic [4:0]  w_hcnt_inc;
    logic [7:0]  w_lcnt_inc;
    logic [9:0]  w_bursts_inc;
    logic        w_fail_now;
    logic [2:0]  w_fail_code;

    // Decode every mismatch condition in one place so the FSM has a single fail path.
    always_comb begin
        w_hcnt_full  = (r_hcnt == HcntMax);
        w_hcnt_inc   = r_hcnt + 5'd1;
        w_lcnt_inc   = r_lcnt + 8'd1;
        w_bursts_inc = r_bursts + 10'd1;
        w_fail_now   = 1'b0;
        w_fail_code  = ErrNone;
        unique case (r_state)
            StWaitFirst: begin
                if (!r_p && (w_lcnt_inc == TimeoutCnt)) begin
                    w_fail_now  = 1'b1;
                    w_fail_code = ErrTimeout;
                end
            end
            StHigh: begin
                if (r_p && w_hcnt_full) begin
                    w_fail_now  = 1'b1;
                    w_fail_code = ErrLong;
                end else if (!r_p && !w_hcnt_full) begin
                    w_fail_now  = 1'b1;
                    w_fail_code = ErrShort;
                end
            end
            StGap: begin
                if (!r_p) begin
                    w_fail_now  = 1'b1;
                    w_fail_code = ErrGap;
                end
            end
            StQuiet: begin
                if (r_p) begin
                    w_fail_now  = 1'b1;
                    w_fail_code = ErrExtra;
                end
            end
            default: ;
        endcase
    end

    // Input register, checker FSM, counters and registered verdict outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_p      <= 1'b0;
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_err    <= ErrNone;
            r_bursts <= '0;
        end else begin
            r_p <= i_pulse_in;
            if (i_arm) begin
                r_state  <= StWaitFirst;
                r_hcnt   <= '0;
                r_lcnt   <= '0;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_pass   <= 1'b0;
                r_fail   <= 1'b0;
                r_err    <= ErrNone;
                r_bursts <= '0;
            end else if (w_fail_now) begin
                // bursts is left untouched so it shows how far the train got
                r_state <= StFail;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_fail  <= 1'b1;
                r_err   <= w_fail_code;
            end else begin
                unique case (r_state)
                    StWaitFirst: begin
                        if (r_p) begin
                            r_state <= StHigh;
                            r_hcnt  <= 5'd1;
                        end else begin
                            r_lcnt <= w_lcnt_inc;
                        end
                    end
                    StHigh: begin
                        if (r_p) begin
                            r_hcnt <= w_hcnt_inc;
                        end else begin
                            // falling edge of a correctly-lengthed burst
                            r_bursts <= w_bursts_inc;
                            if (w_bursts_inc == BurstsLast) begin
                                r_state <= StQuiet;
                                r_lcnt  <= '0;
                            end else begin
                                r_state <= StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (r_p) begin
                            r_state <= StHigh;
                            r_hcnt  <= 5'd1;
                        end
                    end
                    StQuiet: begin
                        r_lcnt <= w_lcnt_inc;
                        if (w_lcnt_inc == QuietCnt) begin
                            r_state <= StPass;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_err   <= ErrNone;
                        end
                    end
                    default: ; // idle, pass and fail hold until arm or reset
                endcase
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_err_code = r_err;
    assign o_bursts   = r_bursts;

endmodule
